// File: rtl/sid_reg_scheduler_pkg.sv
// Shared types for the SID register write-port scheduler: register address,
// buffered host write entry and the registered SID bus beat.
package sid_reg_scheduler_pkg;

  typedef logic [4:0] sid_addr_t;

  // 0x19..0x1F are read-only (pots, osc3, env3); host writes there are rejected.
  localparam sid_addr_t REG_RO_BASE = 5'h19;

  typedef struct packed {
    sid_addr_t   addr;
    logic [7:0]  data;
  } host_wr_t;

  typedef struct packed {
    logic        cs;
    logic        we;
    logic        oe;
    sid_addr_t   addr;
    logic [7:0]  data;
    logic        src;
  } sid_bus_t;

endpackage

// File: rtl/sid_reg_scheduler_if.sv
// CPU bus, host write port and SID register bus grouped for the scheduler.
interface sid_reg_scheduler_if #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned LEVEL_W = 4
);
  logic              slot;
  logic              cpu_cs;
  logic              cpu_we;
  logic              cpu_oe;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_data;
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_data;
  logic              host_clr;
  logic              host_err;
  logic              sid_cs;
  logic              sid_we;
  logic              sid_oe;
  logic [ADDR_W-1:0] sid_addr;
  logic [7:0]        sid_data;
  logic              sid_src;
  logic [LEVEL_W-1:0] fifo_level;

  modport master (
    output slot, cpu_cs, cpu_we, cpu_oe, cpu_addr, cpu_data,
    output host_valid, host_addr, host_data, host_clr,
    input  host_ready, host_err,
    input  sid_cs, sid_we, sid_oe, sid_addr, sid_data, sid_src, fifo_level
  );

  modport slave (
    input  slot, cpu_cs, cpu_we, cpu_oe, cpu_addr, cpu_data,
    input  host_valid, host_addr, host_data, host_clr,
    output host_ready, host_err,
    output sid_cs, sid_we, sid_oe, sid_addr, sid_data, sid_src, fifo_level
  );
endinterface

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO of buffered host writes; extra occupancy bit separates full
// from empty, pointers wrap modulo Depth (power of two).
module sid_wr_fifo
  import sid_reg_scheduler_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LevelW = PtrW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clr_i,
  input  host_wr_t          wdata_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [LevelW-1:0] level_o,
  output logic [LevelW-1:0] level_next_o,
  output host_wr_t          head_o
);

  host_wr_t          mem_q [Depth];
  logic [PtrW-1:0]   wptr_d, wptr_q, rptr_d, rptr_q;
  logic [LevelW-1:0] level_d, level_q;
  logic              do_push, do_pop;

  assign full_o       = (level_q == LevelW'(Depth));
  assign empty_o      = (level_q == '0);
  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign head_o       = mem_q[rptr_q];

  always_comb begin
    do_push = push_i && !full_o && !clr_i;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (clr_i) begin
      // Head was already read this cycle; clearing only drops what remains.
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      level_d = level_q + LevelW'(do_push) - LevelW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sid_reg_scheduler.sv
// Shares the SID register bus between the C64 CPU (absolute priority) and a
// buffered host write port that only uses slots the CPU leaves idle.
module sid_reg_scheduler
  import sid_reg_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 5
) (
  input logic               clk,
  input logic               res_n,
  sid_reg_scheduler_if.slave bus
);

  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic              cpu_grant, accept, addr_ok, push, pop;
  logic              full, empty;
  logic [LevelW-1:0] level, level_next;
  logic              ready_d, ready_q, err_d, err_q;
  host_wr_t          wr_entry, head;
  sid_bus_t          sid_d, sid_q;

  always_comb begin
    cpu_grant = bus.slot && bus.cpu_cs && (bus.cpu_we || bus.cpu_oe);
    accept    = bus.host_valid && bus.host_ready;
    addr_ok   = (bus.host_addr < ADDR_W'(REG_RO_BASE));
    push      = accept && addr_ok && !full;
    err_d     = accept && !addr_ok;
    pop       = bus.slot && !cpu_grant && !empty;
    wr_entry  = '{addr: sid_addr_t'(bus.host_addr), data: bus.host_data};
    // Registered from next-state occupancy so a pop never reaches ready combinationally.
    ready_d   = (level_next < LevelW'(FIFO_DEPTH));

    sid_d = '0;
    if (cpu_grant) begin
      sid_d.cs   = 1'b1;
      sid_d.we   = bus.cpu_we;
      sid_d.oe   = bus.cpu_oe;
      sid_d.addr = sid_addr_t'(bus.cpu_addr);
      sid_d.data = bus.cpu_data;
      sid_d.src  = 1'b0;
    end else if (pop) begin
      sid_d.cs   = 1'b1;
      sid_d.we   = 1'b1;
      sid_d.addr = head.addr;
      sid_d.data = head.data;
      sid_d.src  = 1'b1;
    end
  end

  sid_wr_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (res_n),
    .push_i       (push),
    .pop_i        (pop),
    .clr_i        (bus.host_clr),
    .wdata_i      (wr_entry),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .level_next_o (level_next),
    .head_o       (head)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sid_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sid_q   <= sid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign bus.host_ready = ready_q && !bus.host_clr;
  assign bus.host_err   = err_q;
  assign bus.sid_cs     = sid_q.cs;
  assign bus.sid_we     = sid_q.we;
  assign bus.sid_oe     = sid_q.oe;
  assign bus.sid_addr   = ADDR_W'(sid_q.addr);
  assign bus.sid_data   = sid_q.data;
  assign bus.sid_src    = sid_q.src;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_sid_reg_scheduler.sv
// Directed bench for sid_reg_scheduler: a vector table for single-cycle
// behaviour plus hand sequences for full, flush and asynchronous reset.
module tb_sid_reg_scheduler;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  sid_reg_scheduler_if #(.ADDR_W(5), .LEVEL_W(4)) bus ();

  sid_reg_scheduler #(
    .FIFO_DEPTH (8),
    .ADDR_W     (5)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  typedef struct {
    logic        slot, cs, we, oe;
    logic [4:0]  caddr;
    logic [7:0]  cdata;
    logic        hv;
    logic [4:0]  haddr;
    logic [7:0]  hdata;
    logic        clr;
    logic [16:0] exp_sid;
    logic [3:0]  exp_lvl;
    logic        exp_rdy, exp_err;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [16:0] sidv(input logic cs, input logic we, input logic oe,
                                       input logic [4:0] a, input logic [7:0] d,
                                       input logic src);
    return {cs, we, oe, a, d, src};
  endfunction

  function automatic vec_t mk(input logic slot, input logic cs, input logic we, input logic oe,
                              input logic [4:0] caddr, input logic [7:0] cdata,
                              input logic hv, input logic [4:0] haddr, input logic [7:0] hdata,
                              input logic clr, input logic [16:0] esid, input logic [3:0] elvl,
                              input logic erdy, input logic eerr);
    vec_t v;
    v.slot = slot; v.cs = cs; v.we = we; v.oe = oe; v.caddr = caddr; v.cdata = cdata;
    v.hv = hv; v.haddr = haddr; v.hdata = hdata; v.clr = clr;
    v.exp_sid = esid; v.exp_lvl = elvl; v.exp_rdy = erdy; v.exp_err = eerr;
    return v;
  endfunction

  function automatic logic [16:0] obs();
    return {bus.sid_cs, bus.sid_we, bus.sid_oe, bus.sid_addr, bus.sid_data, bus.sid_src};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.slot = 0; bus.cpu_cs = 0; bus.cpu_we = 0; bus.cpu_oe = 0;
    bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.host_valid = 0; bus.host_addr = '0; bus.host_data = '0; bus.host_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [4:0] a, input logic [7:0] d);
    bus.host_valid = 1; bus.host_addr = a; bus.host_data = d;
    tick();
    bus.host_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    vecs[0]  = mk(0,0,0,0,5'h00,8'h00, 0,5'h00,8'h00,0, 17'h0, 4'd0,1,0);
    vecs[1]  = mk(0,0,0,0,5'h00,8'h00, 1,5'h18,8'h0F,0, 17'h0, 4'd1,1,0);
    vecs[2]  = mk(1,0,0,0,5'h00,8'h00, 0,5'h00,8'h00,0, sidv(1,1,0,5'h18,8'h0F,1), 4'd0,1,0);
    vecs[3]  = mk(0,0,0,0,5'h00,8'h00, 0,5'h00,8'h00,0, 17'h0, 4'd0,1,0);
    vecs[4]  = mk(0,0,0,0,5'h00,8'h00, 1,5'h00,8'h11,0, 17'h0, 4'd1,1,0);
    vecs[5]  = mk(1,1,1,0,5'h04,8'h21, 0,5'h00,8'h00,0, sidv(1,1,0,5'h04,8'h21,0), 4'd1,1,0);
    vecs[6]  = mk(1,0,0,0,5'h00,8'h00, 0,5'h00,8'h00,0, sidv(1,1,0,5'h00,8'h11,1), 4'd0,1,0);
    vecs[7]  = mk(1,1,0,0,5'h07,8'h55, 0,5'h00,8'h00,0, 17'h0, 4'd0,1,0);
    vecs[8]  = mk(0,0,0,0,5'h00,8'h00, 1,5'h1B,8'h77,0, 17'h0, 4'd0,1,1);
    vecs[9]  = mk(0,0,0,0,5'h00,8'h00, 0,5'h00,8'h00,0, 17'h0, 4'd0,1,0);
    vecs[10] = mk(1,1,0,1,5'h1B,8'h00, 0,5'h00,8'h00,0, sidv(1,0,1,5'h1B,8'h00,0), 4'd0,1,0);
    vecs[11] = mk(1,1,0,0,5'h00,8'h00, 1,5'h05,8'hAA,0, 17'h0, 4'd1,1,0);
    vecs[12] = mk(1,0,0,0,5'h00,8'h00, 1,5'h06,8'hBB,0, sidv(1,1,0,5'h05,8'hAA,1), 4'd1,1,0);
    vecs[13] = mk(1,0,0,0,5'h00,8'h00, 0,5'h00,8'h00,0, sidv(1,1,0,5'h06,8'hBB,1), 4'd0,1,0);

    // Reset state while res_n is held low
    repeat (2) @(posedge clk);
    #1;
    check("reset_level", 32'(bus.fifo_level), 0);
    check("reset_ready", 32'(bus.host_ready), 0);
    check("reset_sid", 32'(obs()), 0);
    check("reset_err", 32'(bus.host_err), 0);
    @(negedge clk);
    res_n = 1;
    tick();
    check("release_ready", 32'(bus.host_ready), 1);

    for (int i = 0; i < 14; i++) begin
      bus.slot = vecs[i].slot; bus.cpu_cs = vecs[i].cs; bus.cpu_we = vecs[i].we;
      bus.cpu_oe = vecs[i].oe; bus.cpu_addr = vecs[i].caddr; bus.cpu_data = vecs[i].cdata;
      bus.host_valid = vecs[i].hv; bus.host_addr = vecs[i].haddr;
      bus.host_data = vecs[i].hdata; bus.host_clr = vecs[i].clr;
      tick();
      check($sformatf("vec%0d_sid", i), 32'(obs()), 32'(vecs[i].exp_sid));
      check($sformatf("vec%0d_level", i), 32'(bus.fifo_level), 32'(vecs[i].exp_lvl));
      check($sformatf("vec%0d_ready", i), 32'(bus.host_ready), 32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_err", i), 32'(bus.host_err), 32'(vecs[i].exp_err));
    end
    idle_inputs();
    tick();

    // Full: eight pushes with valid held, ninth stalls until a slot pops
    bus.host_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      bus.host_addr = 5'(i); bus.host_data = 8'(8'h10 + i);
      tick();
      check($sformatf("full_push%0d_level", i), 32'(bus.fifo_level), 32'(i));
      check($sformatf("full_push%0d_ready", i), 32'(bus.host_ready), (i < 8) ? 1 : 0);
    end
    bus.host_addr = 5'd9; bus.host_data = 8'h19;
    tick();
    check("full_stall_level", 32'(bus.fifo_level), 8);
    check("full_stall_ready", 32'(bus.host_ready), 0);
    bus.slot = 1;
    tick();
    bus.slot = 0;
    check("full_pop_sid", 32'(obs()), 32'(sidv(1,1,0,5'd1,8'h11,1)));
    check("full_pop_level", 32'(bus.fifo_level), 7);
    check("full_pop_ready", 32'(bus.host_ready), 1);
    tick();
    bus.host_valid = 0;
    check("full_ninth_level", 32'(bus.fifo_level), 8);
    check("full_ninth_ready", 32'(bus.host_ready), 0);
    check("full_ninth_sid", 32'(obs()), 0);
    for (int i = 2; i <= 9; i++) begin
      bus.slot = 1;
      tick();
      check($sformatf("full_order%0d", i), 32'(obs()), 32'(sidv(1,1,0,5'(i),8'(8'h10 + i),1)));
    end
    bus.slot = 0;
    check("full_drained", 32'(bus.fifo_level), 0);
    tick();

    // Flush coincident with slot and a push attempt
    for (int i = 0; i < 4; i++) push_one(5'(5'h0A + i), 8'(8'hA0 + i));
    check("flush_pre_level", 32'(bus.fifo_level), 4);
    bus.slot = 1; bus.host_clr = 1;
    bus.host_valid = 1; bus.host_addr = 5'h0E; bus.host_data = 8'hEE;
    #1;
    check("flush_ready_low", 32'(bus.host_ready), 0);
    tick();
    check("flush_head_sid", 32'(obs()), 32'(sidv(1,1,0,5'h0A,8'hA0,1)));
    check("flush_level", 32'(bus.fifo_level), 0);
    idle_inputs();
    #1;
    check("flush_ready_back", 32'(bus.host_ready), 1);
    tick();
    check("flush_push_dropped", 32'(bus.fifo_level), 0);
    bus.slot = 1;
    tick();
    bus.slot = 0;
    check("flush_no_issue", 32'(obs()), 0);

    // Asynchronous reset mid-transfer with entries queued
    for (int i = 1; i <= 4; i++) push_one(5'(i), 8'(8'h30 + i));
    bus.slot = 1;
    tick();
    bus.slot = 0;
    check("rst_pre_sid", 32'(obs()), 32'(sidv(1,1,0,5'd1,8'h31,1)));
    check("rst_pre_level", 32'(bus.fifo_level), 3);
    #1 res_n = 0;
    #1;
    check("rst_async_level", 32'(bus.fifo_level), 0);
    check("rst_async_sid", 32'(obs()), 0);
    check("rst_async_ready", 32'(bus.host_ready), 0);
    @(negedge clk);
    res_n = 1;
    #1;
    check("rst_ready_before_edge", 32'(bus.host_ready), 0);
    tick();
    check("rst_ready_after_edge", 32'(bus.host_ready), 1);
    check("rst_level_after", 32'(bus.fifo_level), 0);
    bus.slot = 1;
    tick();
    bus.slot = 0;
    check("rst_no_issue", 32'(obs()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sid_reg_scheduler.md
Name: sid_reg_scheduler

Overview:
- Shares the SID register write port between two requesters.
  - The C64 CPU bus has absolute priority and is never stalled.
  - A secondary host port (loader/MIDI/config controller) uses a valid/ready handshake.
- Host writes are buffered in a small FIFO. They are issued onto the SID register bus only in bus slots the CPU leaves idle.
- Sits between the CPU bus decode / host controller and sid_core's cs/bus inputs.

Parameters:
- FIFO_DEPTH, 8, host write buffer entries; power of two, minimum 2.
- ADDR_W, 5, SID register address width (0x00-0x1F).

Ports:
- clk  in  1  system clock.
- res_n  in  1  asynchronous, active-low reset.
- slot  in  1  one-cycle pulse marking one SID bus slot (once per phi2 cycle).
- cpu_cs  in  1  CPU selects SID this slot.
- cpu_we  in  1  CPU write strobe.
- cpu_oe  in  1  CPU read strobe.
- cpu_addr  in  ADDR_W  CPU register address.
- cpu_data  in  8  CPU write data.
- host_valid  in  1  host write request.
- host_ready  out  1  FIFO can accept.
- host_addr  in  ADDR_W  host register address.
- host_data  in  8  host write data.
- host_clr  in  1  synchronous FIFO flush.
- host_err  out  1  one-cycle pulse: host address rejected.
- sid_cs  out  1  to sid_core cs.
- sid_we  out  1  to sid_core bus we.
- sid_oe  out  1  to sid_core bus oe.
- sid_addr  out  ADDR_W  to sid_core bus addr.
- sid_data  out  8  to sid_core bus data.
- sid_src  out  1  0 = CPU, 1 = host (debug).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (res_n low, asynchronous):
  - FIFO empty, fifo_level = 0.
  - All sid_* outputs = 0, host_err = 0.
  - host_ready = 0 while res_n is low; it rises on the first clk edge after deassertion.
- Host acceptance:
  - A push occurs on a clk edge with host_valid && host_ready && host_addr < 'h19.
  - host_valid && host_ready && host_addr >= 'h19 (read-only registers) is consumed without a push. host_err pulses high the next cycle.
  - host_ready = (fifo_level < FIFO_DEPTH) && !host_clr. It is a registered function of next-state occupancy, so full is seen without a combinational path from the pop.
- Arbitration is evaluated only on the cycle slot is high:
  - CPU grant if cpu_cs && (cpu_we || cpu_oe): forward cpu_we, cpu_oe, cpu_addr, cpu_data; sid_src = 0.
  - Else host grant if FIFO is non-empty: pop head, sid_we = 1, sid_oe = 0; sid_src = 1.
  - Else idle.
- Output timing:
  - sid_* are registered: valid for exactly one clk cycle, the cycle after slot; 0 at all other times.
  - Grant latency is 1 clk from slot.
- Push-to-issue latency: an entry pushed at edge N is eligible at a slot no earlier than cycle N+1.
- Simultaneous push and pop in the same cycle: both happen; occupancy unchanged. Allowed when full (the pop frees a place, but host_ready is still the old registered value, so a push occurs only if host_ready was 1).
- Ordering:
  - FIFO order is strict.
  - Host writes never reorder relative to each other.
  - CPU writes may overtake queued host writes.
- Pointers: read and write pointers wrap modulo FIFO_DEPTH. An extra occupancy bit distinguishes full from empty.
- host_clr:
  - Empties the FIFO at that edge, cancelling any same-cycle push.
  - A pop in the same cycle still drives its entry onto sid_* (entry already read).
- slot while cpu_cs is asserted without a strobe: treated as idle for the CPU, so the host may use the slot.
- No host write is ever dropped silently. The only discard paths are host_err and host_clr.

Decomposition:
- Add to package sid:
  - typedef sid_addr_t (logic [4:0]).
  - constant REG_RO_BASE = 'h19.
  - struct host_wr_t {addr, data}.
- One sub-module, sid_wr_fifo: synchronous FIFO of host_wr_t, parameter DEPTH; ports push/pop/clr/full/empty/level/head. It uses the same async active-low reset.
- Arbiter and output register stay in sid_reg_scheduler.

Test Plan:
- Reset: res_n low mid-transfer with 3 entries queued → fifo_level = 0, sid_* = 0 immediately; host_ready = 1 one clk after release.
- Host only: push (0x18, 0x0F), then slot → sid_we = 1, sid_addr = 0x18, sid_data = 0x0F, sid_src = 1 for one cycle after slot.
- Contention: queue (0x00, 0x11); slot with cpu_cs = 1, cpu_we = 1, (0x04, 0x21) → CPU write issued. The next idle slot issues (0x00, 0x11).
- Full:
  - Push 8 entries, host_valid held → host_ready = 0, 9th not accepted.
  - One idle slot pops → host_ready = 1 the following cycle; 9th accepted. Order 1..9 is preserved at the output.
- Rejection: host_addr = 0x1B → host_err pulse, fifo_level unchanged, no SID write.
- Flush: 4 entries queued, host_clr coincident with slot → head entry issued, fifo_level = 0; a push attempted in the same cycle is discarded.
